vga_timing_gen: RTL and testbench
=================================

# vga_timing_gen

Parametrised VGA timing and test-pattern generator, the next generation of the team's fixed 640x480 `vga_controller`. It runs in the pixel clock domain, fed from the `clk_wiz_0` output, with an optional pixel clock-enable. It produces sync, blanking, pixel coordinates, frame/line strobes and a frame counter. A built-in pattern engine drives 4-bit RGB. A configurable pipeline delay aligns sync and RGB with downstream pixel logic that consumes `x`/`y`.

## Interface
- `H_ACTIVE` 640: visible pixels per line
- `H_FP` 16, `H_SYNC` 96, `H_BP` 48: horizontal porches and sync width, in pixels
- `V_ACTIVE` 480: visible lines
- `V_FP` 10, `V_SYNC` 2, `V_BP` 33: vertical porches and sync width, in lines
- `HSYNC_POL` 0, `VSYNC_POL` 0: active level of each sync (0 = active-low)
- `PIPE_DELAY` 0: extra pixel stages (0..7) applied to sync/video_on/rgb relative to `x`/`y`
- `CW` 12: counter and coordinate width
- `clk` in 1: pixel-domain clock
- `reset_n` in 1: asynchronous active-low reset
- `pix_ce` in 1: pixel advance enable (tie 1 when `clk` is the pixel clock)
- `mode` in 2: pattern select, latched at frame start
- `solid_rgb` in 12: {r,g,b} for mode 3
- `hsync`, `vsync` out 1: sync outputs, delayed
- `video_on` out 1: active-area flag, delayed
- `vga_r`, `vga_g`, `vga_b` out 4 each: pixel colour, delayed; 0 when blanked
- `x`, `y` out CW each: coordinates of the current pixel (undelayed)
- `pos_valid` out 1: `x`/`y` lie in the active area
- `line_start`, `frame_start` out 1: strobes, aligned with `x`/`y`
- `frame_cnt` out 8: completed-frame count

## Operation
- Derived totals: H_TOTAL = sum of H params; V_TOTAL = sum of V params. Both must be < 2^CW, and H_ACTIVE >= 8.
- Counters: `h_cnt` counts 0..H_TOTAL-1 and wraps to 0. On that wrap `v_cnt` advances 0..V_TOTAL-1 and wraps to 0. Counters advance only on cycles with `pix_ce`=1; all other state holds when `pix_ce`=0.
- Stage 0 outputs, registered from the counters:
  - `x`=h_cnt, `y`=v_cnt
  - `pos_valid` = (h_cnt<H_ACTIVE && v_cnt<V_ACTIVE)
  - `line_start` = (h_cnt==0)
  - `frame_start` = (h_cnt==0 && v_cnt==0)
- Sync windows:
  - hsync is active for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC.
  - vsync is active for lines V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, over whole lines.
- Mode latch: an internal `mode_q` loads `mode` on the `pix_ce` cycle whose counters are (0,0). A change in `mode` mid-frame takes effect at the next frame.
- Patterns, computed from stage-0 values:
  - Mode 0, colour bars: BAR_W = H_ACTIVE/8. A bar index increments every BAR_W pixels, resets at each `line_start` and saturates at 7. Colour is r={4{~i[2]}}, g={4{~i[1]}}, b={4{~i[0]}}, so bar 0 is white and bar 7 is black.
  - Mode 1, checker: x[5]^y[5] ? 0xFFF : 0x000.
  - Mode 2, gradient: r=x[7:4], g=y[7:4], b=frame_cnt[3:0].
  - Mode 3, solid: `solid_rgb`.
- Blanking: rgb is forced to 0 whenever `video_on`=0.
- Frame counter: `frame_cnt` increments (mod 256) on each `frame_start` after the first frame following reset. It therefore reads 1 during the second frame.
- Delay line: {hsync, vsync, video_on, rgb} pass through PIPE_DELAY pixel stages, shifted only on `pix_ce`.

## Timing
- Reset values, asserted asynchronously and released synchronously inside the block:
  - counters, `x`, `y`: 0
  - `pos_valid`, `line_start`, `frame_start`, `video_on`: 0
  - rgb: 0; `frame_cnt`: 0; `mode_q`: 0
  - `hsync` = ~HSYNC_POL, `vsync` = ~VSYNC_POL
  - delay-line contents: the inactive values above
- First advance: the first `pix_ce` after release updates outputs for counter state (0,0), so `frame_start` pulses once.
- Latency: `x`/`y`/strobes trail the counters by 1 pix_ce. Sync, video_on and rgb trail by 1+PIPE_DELAY pix_ce events.
- Strobe width: strobes are high for exactly one clock, even when `pix_ce` is sparse, because they are qualified by `pix_ce` and cleared on the next clock.
- Reset mid-frame: all outputs return to their reset values immediately, and the next frame starts at (0,0).

## Test plan
- Reset with `pix_ce`=1 held: all outputs at their reset values; after release, the first `frame_start` appears with x=0, y=0.
- Default params, `pix_ce`=1: hsync is low for 96 clocks starting at x=656; line period is 800 clocks; vsync is low on lines 490-491; `frame_start` period is 420000 clocks.
- `pix_ce` every 4th clock: line period is 3200 clocks; each `line_start` pulse is 1 clock wide; x holds between enables.
- `mode`=0 switched to 3 (`solid_rgb`=0xA5C) mid-frame: bars continue to end of frame; the next frame shows rgb=A,5,C in the active area and 0 in blanking.
- PIPE_DELAY=3, mode 0: at the cycle x=80,y=0 appears, rgb changes from white to 0xFF0 three pix_ce later; video_on falls 3 pix_ce after x=640.
- Assert `reset_n` mid-frame at y=200: hsync/vsync go inactive and rgb 0 within the same cycle; `frame_cnt` reads 0; after release, `frame_start` occurs at (0,0).

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing and test-pattern generator in the pixel clock domain.
// Stage-0 outputs are registered from the h/v counters; sync/video_on/rgb then pass through PIPE_DELAY stages.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter bit          HSYNC_POL  = 1'b0,
  parameter bit          VSYNC_POL  = 1'b0,
  parameter int unsigned PIPE_DELAY = 0,
  parameter int unsigned CW         = 12
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          pix_ce,
  input  logic [1:0]    mode,
  input  logic [11:0]   solid_rgb,
  output logic          hsync,
  output logic          vsync,
  output logic          video_on,
  output logic [3:0]    vga_r,
  output logic [3:0]    vga_g,
  output logic [3:0]    vga_b,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          pos_valid,
  output logic          line_start,
  output logic          frame_start,
  output logic [7:0]    frame_cnt
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT    = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT    = CW'(V_ACTIVE);
  localparam logic [CW-1:0] HS_START = CW'(H_ACTIVE + H_FP);
  localparam logic [CW-1:0] HS_END   = CW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CW-1:0] VS_START = CW'(V_ACTIVE + V_FP);
  localparam logic [CW-1:0] VS_END   = CW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CW-1:0] BAR_LAST = CW'(H_ACTIVE / 8 - 1);

  typedef struct packed {
    logic        hsync;
    logic        vsync;
    logic        video_on;
    logic [11:0] rgb;
  } vid_t;

  localparam vid_t VID_IDLE = '{hsync: ~HSYNC_POL, vsync: ~VSYNC_POL, video_on: 1'b0, rgb: 12'h000};

  logic          rst_meta;
  logic          rst_n;
  logic [CW-1:0] h_cnt;
  logic [CW-1:0] v_cnt;
  logic [CW-1:0] bar_px;
  logic [2:0]    bar_idx;
  logic [1:0]    mode_q;
  logic          seen_frame;
  logic          frame_origin;
  logic          active;
  logic [1:0]    mode_eff;
  logic [7:0]    fc_next;
  logic [11:0]   pat_rgb;
  vid_t          stage0;
  vid_t          vid_out;

  // Reset asserts immediately with reset_n but is released on a clock edge.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses <= so every flop samples pre-edge values, independent of statement order.
    if (!reset_n) {rst_n, rst_meta} <= 2'b00;
    else          {rst_n, rst_meta} <= {rst_meta, 1'b1};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

  // Bar index tracks h_cnt without a divider: bar_px counts pixels within the current bar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bar_px  <= '0;
      bar_idx <= '0;
    end else if (pix_ce) begin
      if (h_cnt == H_LAST) begin
        bar_px  <= '0;
        bar_idx <= '0;
      end else if (bar_px == BAR_LAST) begin
        bar_px  <= '0;
        bar_idx <= (bar_idx == 3'd7) ? 3'd7 : bar_idx + 3'd1;
      end else begin
        bar_px <= bar_px + 1'b1;
      end
    end
  end

  assign frame_origin = (h_cnt == '0) && (v_cnt == '0);
  assign active       = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  // The origin pixel already uses the mode being latched on this cycle.
  assign mode_eff     = frame_origin ? mode : mode_q;
  assign fc_next      = (frame_origin && seen_frame) ? frame_cnt + 8'd1 : frame_cnt;

  always_comb begin
    // NOTE: default assignment first so no path leaves pat_rgb unassigned and no latch is inferred.
    pat_rgb = 12'h000;
    case (mode_eff)
      2'd0:    pat_rgb = {{4{~bar_idx[2]}}, {4{~bar_idx[1]}}, {4{~bar_idx[0]}}};
      2'd1:    pat_rgb = (h_cnt[5] ^ v_cnt[5]) ? 12'hFFF : 12'h000;
      2'd2:    pat_rgb = {h_cnt[7:4], v_cnt[7:4], fc_next[3:0]};
      default: pat_rgb = solid_rgb;
    endcase
    if (!active) pat_rgb = 12'h000;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x           <= '0;
      y           <= '0;
      pos_valid   <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      frame_cnt   <= 8'd0;
      mode_q      <= 2'd0;
      seen_frame  <= 1'b0;
      stage0      <= VID_IDLE;
    end else begin
      // Strobes are qualified by pix_ce so they last one clock even with a sparse enable.
      line_start  <= pix_ce && (h_cnt == '0);
      frame_start <= pix_ce && frame_origin;
      if (pix_ce) begin
        x         <= h_cnt;
        y         <= v_cnt;
        pos_valid <= active;
        frame_cnt <= fc_next;
        stage0    <= '{hsync:    ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? HSYNC_POL : ~HSYNC_POL,
                       vsync:    ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? VSYNC_POL : ~VSYNC_POL,
                       video_on: active,
                       rgb:      pat_rgb};
        if (frame_origin) begin
          mode_q     <= mode;
          seen_frame <= 1'b1;
        end
      end
    end
  end

  generate
    if (PIPE_DELAY == 0) begin : g_no_delay
      assign vid_out = stage0;
    end else begin : g_delay
      vid_t pipe [PIPE_DELAY];
      always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: delay-line stages are reset, unlike a RAM, so idle sync levels show before the first pixel drains out.
        if (!rst_n) begin
          for (int i = 0; i < int'(PIPE_DELAY); i++) pipe[i] <= VID_IDLE;
        end else if (pix_ce) begin
          pipe[0] <= stage0;
          for (int i = 1; i < int'(PIPE_DELAY); i++) pipe[i] <= pipe[i-1];
        end
      end
      assign vid_out = pipe[PIPE_DELAY-1];
    end
  endgenerate

  assign hsync                 = vid_out.hsync;
  assign vsync                 = vid_out.vsync;
  assign video_on              = vid_out.video_on;
  assign {vga_r, vga_g, vga_b} = vid_out.rgb;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench for vga_timing_gen: default 640x480, PIPE_DELAY=3 and a tiny 24x10 raster
// run side by side from shared inputs so that whole-frame behaviour fits in a short run.
module tb_vga_timing_gen;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pix_ce;
  logic [1:0]  mode;
  logic [11:0] solid_rgb;

  logic        def_hs, def_vs, def_vo, def_pv, def_ls, def_fs;
  logic [3:0]  def_r, def_g, def_b;
  logic [11:0] def_x, def_y;
  logic [7:0]  def_fc;

  logic        d3_hs, d3_vs, d3_vo, d3_pv, d3_ls, d3_fs;
  logic [3:0]  d3_r, d3_g, d3_b;
  logic [11:0] d3_x, d3_y;
  logic [7:0]  d3_fc;

  logic        sm_hs, sm_vs, sm_vo, sm_pv, sm_ls, sm_fs;
  logic [3:0]  sm_r, sm_g, sm_b;
  logic [11:0] sm_x, sm_y;
  logic [7:0]  sm_fc;

  int total = 0;
  int bad   = 0;
  int phase = 0;
  int ce_div = 1;

  always #5 clk = ~clk;

  vga_timing_gen u_def (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(def_hs), .vsync(def_vs), .video_on(def_vo), .vga_r(def_r), .vga_g(def_g), .vga_b(def_b),
    .x(def_x), .y(def_y), .pos_valid(def_pv), .line_start(def_ls), .frame_start(def_fs), .frame_cnt(def_fc)
  );

  vga_timing_gen #(.PIPE_DELAY(3)) u_d3 (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(d3_hs), .vsync(d3_vs), .video_on(d3_vo), .vga_r(d3_r), .vga_g(d3_g), .vga_b(d3_b),
    .x(d3_x), .y(d3_y), .pos_valid(d3_pv), .line_start(d3_ls), .frame_start(d3_fs), .frame_cnt(d3_fc)
  );

  vga_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(6),  .V_FP(1), .V_SYNC(2), .V_BP(1)
  ) u_sm (
    .clk(clk), .reset_n(reset_n), .pix_ce(pix_ce), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(sm_hs), .vsync(sm_vs), .video_on(sm_vo), .vga_r(sm_r), .vga_g(sm_g), .vga_b(sm_b),
    .x(sm_x), .y(sm_y), .pos_valid(sm_pv), .line_start(sm_ls), .frame_start(sm_fs), .frame_cnt(sm_fc)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then set pix_ce for the coming rising edge.
  task automatic tick();
    @(negedge clk);
    phase++;
    pix_ce = ((phase % ce_div) == 0);
  endtask

  // sel: 0 def line_start, 1 sm frame_start, 2 def frame_start, 3 sm y==3
  task automatic wait_for(input int sel, input int max_ticks, output bit found, output int cnt);
    found = 1'b0;
    cnt   = 0;
    for (int i = 0; i < max_ticks; i++) begin
      tick();
      cnt++;
      case (sel)
        0:       found = (def_ls === 1'b1);
        1:       found = (sm_fs === 1'b1);
        2:       found = (def_fs === 1'b1);
        default: found = (sm_y === 12'd3);
      endcase
      if (found) break;
    end
  endtask

  bit          found;
  int          cnt, sx, sy, bi;
  int          def_pos_err, sm_sync_err, sm_pos_err, sm_rgb_err, sm_fc_err;
  int          hs_low, hs_first, ls2, sm_fs2;
  logic        exp_hs, exp_vs, exp_vo;
  logic [2:0]  ib;
  logic [11:0] exp_rgb;
  logic [11:0] d3_rgb_82, d3_rgb_83, def_rgb_100, def_rgb_600;
  logic        d3_vo_642, d3_vo_643, def_vo_639, def_vo_640;

  initial begin
    reset_n   = 1'b0;
    pix_ce    = 1'b1;
    mode      = 2'd0;
    solid_rgb = 12'hA5C;
    repeat (3) tick();

    // Reset state with pix_ce held high
    check("rst_hsync",   def_hs, 1);
    check("rst_vsync",   def_vs, 1);
    check("rst_video",   def_vo, 0);
    check("rst_rgb",     {def_r, def_g, def_b}, 0);
    check("rst_xy",      {def_x, def_y}, 0);
    check("rst_strobes", {def_pv, def_ls, def_fs}, 0);
    check("rst_fc",      def_fc, 0);
    check("rst_d3_sync", {d3_hs, d3_vs, d3_vo}, 3'b110);

    reset_n = 1'b1;
    wait_for(2, 8, found, cnt);
    check("first_fs_seen", found, 1);
    check("first_fs_xy",   {def_x, def_y}, 0);
    check("first_fs_ls",   {def_ls, def_pv}, 2'b11);

    def_pos_err = 0; sm_sync_err = 0; sm_pos_err = 0; sm_rgb_err = 0; sm_fc_err = 0;
    hs_low = 0; hs_first = -1; ls2 = -1; sm_fs2 = -1;
    for (int k = 1; k < 1000; k++) begin
      tick();
      if (k == 1) check("fs_width", def_fs, 0);
      if (def_x !== 12'(k % 800) || def_y !== 12'(k / 800) || def_pv !== ((k % 800) < 640))
        def_pos_err++;
      if (k < 800 && def_hs === 1'b0) begin
        hs_low++;
        if (hs_first < 0) hs_first = k;
      end
      if (ls2 < 0 && def_ls === 1'b1) ls2 = k;
      if (k == 82)  d3_rgb_82   = {d3_r, d3_g, d3_b};
      if (k == 83)  d3_rgb_83   = {d3_r, d3_g, d3_b};
      if (k == 642) d3_vo_642   = d3_vo;
      if (k == 643) d3_vo_643   = d3_vo;
      if (k == 100) def_rgb_100 = {def_r, def_g, def_b};
      if (k == 600) def_rgb_600 = {def_r, def_g, def_b};
      if (k == 639) def_vo_639  = def_vo;
      if (k == 640) def_vo_640  = def_vo;

      sx = k % 24;
      sy = (k / 24) % 10;
      exp_hs = !(sx >= 18 && sx < 21);
      exp_vs = !(sy == 7 || sy == 8);
      exp_vo = (sx < 16) && (sy < 6);
      bi = (sx / 2 > 7) ? 7 : sx / 2;
      ib = 3'(bi);
      exp_rgb = exp_vo ? {{4{~ib[2]}}, {4{~ib[1]}}, {4{~ib[0]}}} : 12'h000;
      if (sm_hs !== exp_hs || sm_vs !== exp_vs || sm_vo !== exp_vo) sm_sync_err++;
      if (sm_x !== 12'(sx) || sm_y !== 12'(sy) || sm_fs !== (sx == 0 && sy == 0) || sm_ls !== (sx == 0))
        sm_pos_err++;
      if ({sm_r, sm_g, sm_b} !== exp_rgb) sm_rgb_err++;
      if (sm_fc !== 8'(k / 240)) sm_fc_err++;
      if (sm_fs2 < 0 && sm_fs === 1'b1) sm_fs2 = k;
    end
    check("def_xy_track",   def_pos_err, 0);
    check("hsync_start_x",  hs_first, 656);
    check("hsync_width",    hs_low, 96);
    check("line_period",    ls2, 800);
    check("def_bar1_rgb",   def_rgb_100, 12'hFF0);
    check("def_bar7_rgb",   def_rgb_600, 12'h000);
    check("def_vo_edge",    {def_vo_639, def_vo_640}, 2'b10);
    check("d3_rgb_x79",     d3_rgb_82, 12'hFFF);
    check("d3_rgb_x80",     d3_rgb_83, 12'hFF0);
    check("d3_vo_edge",     {d3_vo_642, d3_vo_643}, 2'b10);
    check("sm_sync_track",  sm_sync_err, 0);
    check("sm_pos_track",   sm_pos_err, 0);
    check("sm_bars_track",  sm_rgb_err, 0);
    check("sm_frame_cnt",   sm_fc_err, 0);
    check("sm_frame_period", sm_fs2, 240);

    // Sparse enable: one pix_ce every 4 clocks
    ce_div = 4;
    wait_for(0, 4000, found, cnt);
    check("sparse_ls_seen", found, 1);
    check("sparse_ls_xy",   {def_x, def_y}, {12'd0, 12'd2});
    tick();
    check("sparse_ls_width", def_ls, 0);
    tick(); tick();
    check("sparse_x_hold",  def_x, 0);
    tick();
    check("sparse_x_adv",   def_x, 1);
    wait_for(0, 4000, found, cnt);
    check("sparse_line_period", cnt + 4, 3200);

    // Mode switch 0 -> 3 mid-frame on the small raster
    ce_div = 1;
    wait_for(1, 300, found, cnt);
    check("ms_fs_seen", found, 1);
    repeat (50) tick();
    mode = 2'd3;
    tick(); tick();
    check("ms_bars_continue", {sm_x, sm_y, sm_r, sm_g, sm_b}, {12'd4, 12'd2, 12'hF0F});
    wait_for(1, 300, found, cnt);
    check("ms_next_fs", cnt, 188);
    check("ms_solid_origin", {sm_vo, sm_r, sm_g, sm_b}, {1'b1, 12'hA5C});
    repeat (20) tick();
    check("ms_solid_blank", {sm_vo, sm_r, sm_g, sm_b}, {1'b0, 12'h000});
    repeat (9) tick();
    check("ms_solid_active", {sm_x, sm_r, sm_g, sm_b}, {12'd5, 12'hA5C});

    // Reset mid-frame on line 3 of the small raster
    wait_for(3, 300, found, cnt);
    check("mr_line3_seen", found, 1);
    reset_n = 1'b0;
    mode    = 2'd2;
    #1;
    check("mr_sync_idle", {sm_hs, sm_vs, sm_vo}, 3'b110);
    check("mr_rgb_zero",  {sm_r, sm_g, sm_b}, 0);
    check("mr_fc_zero",   sm_fc, 0);
    check("mr_xy_zero",   {sm_x, sm_y}, 0);
    check("mr_d3_idle",   {d3_hs, d3_vs, d3_vo, d3_r, d3_g, d3_b}, {3'b110, 12'h000});
    repeat (3) tick();
    reset_n = 1'b1;
    wait_for(1, 8, found, cnt);
    check("mr_fs_seen",   found, 1);
    check("mr_fs_xy",     {sm_x, sm_y}, 0);
    check("grad_f0_rgb",  {sm_r, sm_g, sm_b}, 12'h000);
    repeat (240) tick();
    check("grad_f1_fs",   {sm_fs, sm_fc}, {1'b1, 8'd1});
    check("grad_f1_rgb",  {sm_r, sm_g, sm_b}, 12'h001);
    check("grad_def_rgb", {def_x, def_r, def_g, def_b}, {12'd240, 12'hF00});

    // Checker pattern on the default raster
    mode    = 2'd1;
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    wait_for(2, 8, found, cnt);
    check("ck_fs_seen", found, 1);
    repeat (32) tick();
    check("ck_x32", {def_x, def_r, def_g, def_b}, {12'd32, 12'hFFF});
    repeat (32) tick();
    check("ck_x64", {def_x, def_r, def_g, def_b}, {12'd64, 12'h000});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
